pc_gen: RTL
===========

Name: pc_gen

Overview:
Parametrised next-generation program-counter generator for the fetch stage of the five-stage pipeline.
- Holds the fetch PC and the instruction-memory chip enable.
- Advances sequentially, taking redirects from ID (branch/jump) and from the exception/flush path.
- A one-entry pending-redirect buffer keeps a branch that arrives while fetch is stalled from being lost.
- Reset vector, address width, instruction size and stall-vector width are parameters.

Parameters:
ADDR_W, 32, width of pc and all redirect addresses
RESET_VEC, 32'h0000_0000, PC value held during and immediately after reset
INST_BYTES, 4, sequential increment; power of two
STALL_W, 6, width of the pipeline stall vector; bit 0 is the fetch-stage stall

Ports:
clk  in  1  single clock; all state updates on rising edge
rst  in  1  asynchronous, active-low reset
stall  in  STALL_W  pipeline stall vector; only stall[0] is used here
flush_i  in  1  exception/flush redirect request
flush_addr_i  in  ADDR_W  flush/exception handler address
branch_flag_i  in  1  branch/jump taken, from ID
branch_target_addr_i  in  ADDR_W  branch/jump target, from ID
pc  out  ADDR_W  current fetch address
ce  out  1  instruction-memory chip enable
pend_o  out  1  a redirect is buffered awaiting stall release
misalign_o  out  1  only with PC_ALIGN_CHECK_EN: registered misaligned-target pulse

Behaviour:
- Reset behaviour:
  - While rst=0, asynchronously: pc=RESET_VEC, ce=0, pend_o=0, misalign_o=0, state=IDLE, pending address=0.
- States: IDLE, RUN.
  - IDLE: first rising edge after rst release sets ce<=1 and moves to RUN. pc stays RESET_VEC, so RESET_VEC is the first fetched address.
  - IDLE: all redirect and stall inputs are ignored.
  - RUN: stays in RUN until reset.
- RUN update priority, evaluated per rising edge:
  1. flush_i=1: pc<=flush_addr_i. Pending buffer is cleared. Takes effect even if stall[0]=1. Any simultaneous branch is discarded.
  2. stall[0]=1 and branch_flag_i=1: pc holds. Buffer captures branch_target_addr_i and pend_o<=1. A newer branch overwrites an older pending one.
  3. stall[0]=1, no branch: pc and buffer hold.
  4. stall[0]=0 and branch_flag_i=1: pc<=branch_target_addr_i. Buffer is cleared; the live branch wins over the pending one.
  5. stall[0]=0 and pend_o=1: pc<=pending address, pend_o<=0.
  6. Otherwise: pc<=pc+INST_BYTES, truncated to ADDR_W (wraps all-ones region to 0, no flag).
- Latency: a redirect presented in cycle N appears on pc in cycle N+1. A buffered redirect appears one cycle after stall[0] falls.
- ce is 1 in every RUN cycle, including stalled ones; pc is simply held.
- Reset asserted mid-operation: all state returns to reset values immediately; any pending redirect is lost.
- Redirect addresses are loaded verbatim; no alignment enforcement (see optional feature).

Optional Feature:
PC_ALIGN_CHECK_EN
- Defined:
  - Any flush or branch address (live or captured) with nonzero low log2(INST_BYTES) bits has those bits cleared before loading or capturing.
  - misalign_o pulses 1 for exactly one cycle, registered and aligned with the pc update or capture.
- Undefined: addresses are loaded unmodified, misalign_o is tied 0, and no checking logic exists.

Decomposition:
- Shared defines/package (pc_pkg): state encoding (IDLE, RUN), fetch stall index (0), default INST_BYTES, RESET_VEC default, enable/disable constants.
- One sub-module, pc_redirect_buf: the one-entry pending-redirect register.
  - Inputs: capture, clear, addr.
  - Outputs: valid, addr.
  - Resets asynchronously to empty.

Test Plan:
- Reset release, no stall, ADDR_W=32, RESET_VEC=32'hBFC0_0000 -> ce=0 during reset. Cycle 1 after release: ce=1, pc=BFC00000. Following cycles: BFC00004, BFC00008.
- stall[0]=1 for 3 cycles; branch_flag_i=1 to 32'h0000_0100 in stall cycle 1 -> pc holds, pend_o=1. First unstalled edge: pc=00000100, pend_o=0.
- Two branches (0x200 then 0x300) during a stall -> after release pc=0x300. Branch 0x400 arriving on the release cycle itself -> pc=0x400, buffer cleared.
- flush_i=1, flush_addr_i=32'h0000_0380 with stall[0]=1 and branch_flag_i=1 -> next pc=00000380, pend_o=0.
- pc=32'hFFFF_FFFC, no redirect -> next pc=0. Reset asserted mid-run with pend_o=1 -> pc=RESET_VEC, ce=0, pend_o=0 without waiting for a clock edge.
- With PC_ALIGN_CHECK_EN, branch to 32'h0000_0102 -> pc=00000100, misalign_o=1 for one cycle. Without the macro -> pc=00000102, misalign_o=0.

Source files
------------

// File: rtl/pc_gen_pkg.sv
// pc_gen_pkg: shared state encoding and defaults for the fetch PC generator (package pc_pkg).
package pc_pkg;
  typedef enum logic {IDLE, RUN} state_e;
  localparam int          FETCH_STALL_IDX = 0;
  localparam int          DEF_INST_BYTES  = 4;
  localparam logic [31:0] DEF_RESET_VEC   = 32'h0000_0000;
  localparam logic        EN              = 1'b1;
  localparam logic        DIS             = 1'b0;
endpackage

// File: rtl/pc_gen_if.sv
// pc_gen_if: pipeline-side redirect/stall bus and fetch outputs of pc_gen.
interface pc_gen_if #(
  parameter int ADDR_W  = 32,
  parameter int STALL_W = 6
);
  logic [STALL_W-1:0] stall;
  logic               flush_i;
  logic [ADDR_W-1:0]  flush_addr_i;
  logic               branch_flag_i;
  logic [ADDR_W-1:0]  branch_target_addr_i;
  logic [ADDR_W-1:0]  pc;
  logic               ce;
  logic               pend_o;
  logic               misalign_o;
  modport master (
    output stall, flush_i, flush_addr_i, branch_flag_i, branch_target_addr_i,
    input  pc, ce, pend_o, misalign_o
  );
  modport slave (
    input  stall, flush_i, flush_addr_i, branch_flag_i, branch_target_addr_i,
    output pc, ce, pend_o, misalign_o
  );
endinterface

// File: rtl/pc_gen_redirect_buf.sv
// pc_redirect_buf: one-entry pending-redirect register; clear wins over capture.
module pc_redirect_buf #(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              capture_i,
  input  logic              clear_i,
  input  logic [ADDR_W-1:0] addr_i,
  output logic              valid_o,
  output logic [ADDR_W-1:0] addr_o
);
  logic              valid_q;
  logic [ADDR_W-1:0] addr_q;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid_q <= 1'b0;
      addr_q  <= '0;
    end else if (clear_i) begin
      valid_q <= 1'b0;
    end else if (capture_i) begin
      valid_q <= 1'b1;
      addr_q  <= addr_i;
    end
  end
  assign valid_o = valid_q;
  assign addr_o  = addr_q;
endmodule

// File: rtl/pc_gen.sv
// pc_gen: fetch PC / chip-enable generator with flush, branch and buffered-redirect handling.
// Optional PC_ALIGN_CHECK_EN: clears misaligned redirect low bits and pulses misalign_o.
module pc_gen
  import pc_pkg::*;
#(
  parameter int              ADDR_W     = 32,
  parameter logic [ADDR_W-1:0] RESET_VEC = ADDR_W'(DEF_RESET_VEC),
  parameter int              INST_BYTES = DEF_INST_BYTES,
  parameter int              STALL_W    = 6
) (
  input logic      clk,
  input logic      rst,
  pc_gen_if.slave  bus
);
  state_e            state_q;
  logic [ADDR_W-1:0] pc_q, pc_d, fa, ba, pend_addr;
  logic              ce_q, run, stall0, cap, clr, pend;
  logic              unused_stall;
  assign unused_stall = ^bus.stall;
  assign run    = state_q == RUN;
  assign stall0 = bus.stall[FETCH_STALL_IDX];
  assign cap    = run & ~bus.flush_i & stall0 & bus.branch_flag_i;
  // any unstalled RUN cycle consumes or supersedes whatever is buffered
  assign clr    = run & (bus.flush_i | ~stall0);
`ifdef PC_ALIGN_CHECK_EN
  localparam logic [ADDR_W-1:0] MASK = ADDR_W'(INST_BYTES - 1);
  logic mis_q, mis_d;
  assign fa    = bus.flush_addr_i & ~MASK;
  assign ba    = bus.branch_target_addr_i & ~MASK;
  assign mis_d = run & (bus.flush_i ? |(bus.flush_addr_i & MASK)
                                    : bus.branch_flag_i & |(bus.branch_target_addr_i & MASK));
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) mis_q <= 1'b0;
    else      mis_q <= mis_d;
  end
  assign bus.misalign_o = mis_q;
`else
  assign fa             = bus.flush_addr_i;
  assign ba             = bus.branch_target_addr_i;
  assign bus.misalign_o = 1'b0;
`endif
  always_comb begin
    pc_d = !run              ? pc_q :
           bus.flush_i       ? fa :
           stall0            ? pc_q :
           bus.branch_flag_i ? ba :
           pend              ? pend_addr :
                               pc_q + ADDR_W'(INST_BYTES);
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      pc_q    <= RESET_VEC;
      ce_q    <= 1'b0;
    end else begin
      pc_q <= pc_d;
      if (state_q == IDLE) begin
        state_q <= RUN;
        ce_q    <= 1'b1;
      end
    end
  end
  pc_redirect_buf #(.ADDR_W(ADDR_W)) u_buf (
    .clk       (clk),
    .rst       (rst),
    .capture_i (cap),
    .clear_i   (clr),
    .addr_i    (ba),
    .valid_o   (pend),
    .addr_o    (pend_addr)
  );
  assign bus.pc     = pc_q;
  assign bus.ce     = ce_q;
  assign bus.pend_o = pend;
endmodule
